// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, memory
// geometry and requester identifiers.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int         MEM_BYTES  = 256;
    localparam logic [2:0] ALIGN_MASK = 3'b111;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_AUX  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. A lone requester always wins; on a tie the
// pointer picks the winner, and each accept hands priority to the loser.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic rr_ptr;

    // Grant selection: single valid wins, tie resolved by rr_ptr.
    always_comb begin
        gnt_id = rr_ptr;
        if (req == 2'b01)      gnt_id = REQ_CORE;
        else if (req == 2'b10) gnt_id = REQ_AUX;
        gnt = 2'b00;
        if (req != 2'b00) gnt = (gnt_id == REQ_AUX) ? 2'b10 : 2'b01;
    end

    // Pointer moves to the other requester on every accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    rr_ptr <= REQ_CORE;
        else if (accept) rr_ptr <= ~gnt_id;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer in front of the single-port data memory. One transaction
// in flight: IDLE accepts, ACCESS drives the memory for one cycle, RESP shows
// a one-cycle response to the owner. Bad addresses skip ACCESS entirely.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = dmem_pkg::MEM_BYTES
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              r0_req_valid,
    output logic              r0_req_ready,
    input  logic              r0_req_write,
    input  logic [ADDR_W-1:0] r0_req_addr,
    input  logic [DATA_W-1:0] r0_req_wdata,
    output logic              r0_rsp_valid,
    output logic [DATA_W-1:0] r0_rsp_rdata,
    output logic              r0_rsp_err,

    input  logic              r1_req_valid,
    output logic              r1_req_ready,
    input  logic              r1_req_write,
    input  logic [ADDR_W-1:0] r1_req_addr,
    input  logic [DATA_W-1:0] r1_req_wdata,
    output logic              r1_rsp_valid,
    output logic [DATA_W-1:0] r1_rsp_rdata,
    output logic              r1_rsp_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    // Highest legal word address; the compare spans the full address width,
    // so any stray upper bit makes the access out of range.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 8);

    state_e              state, state_nx;
    logic [1:0]          gnt;
    logic                gnt_id;
    logic                accept;
    logic                sel_write, sel_err;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                lat_write, lat_id;
    logic [1:0]          rsp_valid, rsp_err;
    logic [1:0][DATA_W-1:0] rsp_rdata;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset_n(reset_n),
        .req    ({r1_req_valid, r0_req_valid}),
        .accept (accept),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // Payload of the granted requester and its address check.
    always_comb begin
        sel_write = (gnt_id == REQ_AUX) ? r1_req_write : r0_req_write;
        sel_addr  = (gnt_id == REQ_AUX) ? r1_req_addr  : r0_req_addr;
        sel_wdata = (gnt_id == REQ_AUX) ? r1_req_wdata : r0_req_wdata;
        sel_err   = ((sel_addr[2:0] & ALIGN_MASK) != 3'b000) || (sel_addr > LAST_ADDR);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state and handshake: ready only exists in IDLE.
    always_comb begin
        state_nx     = state;
        accept       = 1'b0;
        r0_req_ready = 1'b0;
        r1_req_ready = 1'b0;
        case (state)
            IDLE: begin
                if (gnt != 2'b00) begin
                    accept       = 1'b1;
                    r0_req_ready = gnt[0];
                    r1_req_ready = gnt[1];
                    state_nx     = sel_err ? RESP : ACCESS;
                end
            end
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: memory controls live for exactly the ACCESS cycle, response
    // registers for exactly the RESP cycle; everything else falls back to 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            lat_write <= 1'b0;
            lat_id    <= REQ_CORE;
            rsp_valid <= '0;
            rsp_err   <= '0;
            rsp_rdata <= '0;
        end else begin
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            rsp_valid <= '0;
            rsp_err   <= '0;
            rsp_rdata <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_write <= sel_write;
                        lat_id    <= gnt_id;
                        if (sel_err) begin
                            rsp_valid[gnt_id] <= 1'b1;
                            rsp_err[gnt_id]   <= 1'b1;
                        end else begin
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_wdata;
                            mem_write <= sel_write;
                            mem_read  <= ~sel_write;
                        end
                    end
                end
                ACCESS: begin
                    rsp_valid[lat_id] <= 1'b1;
                    rsp_rdata[lat_id] <= lat_write ? '0 : mem_rdata;
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state != IDLE);
    assign r0_rsp_valid = rsp_valid[REQ_CORE];
    assign r0_rsp_err   = rsp_err[REQ_CORE];
    assign r0_rsp_rdata = rsp_rdata[REQ_CORE];
    assign r1_rsp_valid = rsp_valid[REQ_AUX];
    assign r1_rsp_err   = rsp_err[REQ_AUX];
    assign r1_rsp_rdata = rsp_rdata[REQ_AUX];

endmodule
